// File: rtl/pwd_pkg.sv
// Shared types and constants for the password lockout controller.
package pwd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        OPEN,
        LOCKOUT
    } state_t;

    localparam int SYM_W             = 2;
    localparam int DEF_TIMEOUT       = 16;
    localparam int DEF_UNLOCK_CYCLES = 20;
    localparam int DEF_LOCK_CYCLES   = 50;

    // Width needed to hold the largest of the three timer reload values.
    function automatic int tmr_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

    localparam int TMR_W = tmr_width(DEF_TIMEOUT, DEF_UNLOCK_CYCLES, DEF_LOCK_CYCLES);

endpackage

// File: rtl/pwd_timer.sv
// Loadable down-counter; expired marks the last cycle of a loaded interval.
module pwd_timer
    import pwd_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // A value of N loaded at edge E makes the edge at E+N the expiry edge.
    assign expired = (cnt == W'(1));

endmodule

// File: rtl/pwd_lockout_ctrl.sv
// Password entry sequencer with timed unlock, failure counting and lockout.
module pwd_lockout_ctrl
    import pwd_pkg::*;
#(
    parameter int                         CODE_LEN      = 4,
    parameter logic [SYM_W*CODE_LEN-1:0]  DEFAULT_CODE  = 8'b11_01_10_10,
    parameter int                         MAX_FAIL      = 3,
    parameter int                         TIMEOUT       = DEF_TIMEOUT,
    parameter int                         UNLOCK_CYCLES = DEF_UNLOCK_CYCLES,
    parameter int                         LOCK_CYCLES   = DEF_LOCK_CYCLES
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            key_valid,
    input  logic [SYM_W-1:0]                key,
    input  logic                            prog,
    output logic                            unlock,
    output logic                            locked_out,
    output logic                            busy,
    output logic                            bad_attempt,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

    localparam int              FW       = $clog2(MAX_FAIL + 1);
    localparam int              IW       = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int              TW       = tmr_width(TIMEOUT, UNLOCK_CYCLES, LOCK_CYCLES);
    localparam logic [IW-1:0]   LAST     = IW'(CODE_LEN - 1);
    localparam logic [FW-1:0]   FAIL_MAX = FW'(MAX_FAIL);

    state_t                          state;
    logic [CODE_LEN-1:0][SYM_W-1:0]  code, shadow, shadow_next;
    logic [IW-1:0]                   idx, pidx;
    logic                            mismatch;

    logic            tmr_load, tmr_expired;
    logic [TW-1:0]   tmr_val;
    logic            accept, attempt_mm, attempt_done, timeout;
    logic            fail_evt, pass_evt, to_lock, prog_wr, prog_done;
    logic [FW-1:0]   fail_next;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        accept       = key_valid && ((state == IDLE) || (state == ENTRY));
        attempt_mm   = mismatch || (key != code[idx]);
        attempt_done = accept && (idx == LAST);
        timeout      = (state == ENTRY) && !key_valid && tmr_expired;
        fail_evt     = (attempt_done && attempt_mm) || timeout;
        pass_evt     = attempt_done && !attempt_mm;
        fail_next    = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + 1'b1;
        to_lock      = fail_evt && (fail_next == FAIL_MAX);
        // Expiry beats a simultaneous programming strobe.
        prog_wr      = (state == OPEN) && !tmr_expired && key_valid && prog;
        prog_done    = prog_wr && (pidx == LAST);

        shadow_next       = shadow;
        shadow_next[pidx] = key;

        tmr_load = 1'b0;
        tmr_val  = '0;
        if (pass_evt) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(UNLOCK_CYCLES);
        end else if (to_lock) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(LOCK_CYCLES);
        end else if (accept && !attempt_done) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(TIMEOUT);
        end else if (prog_wr && !prog_done) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(UNLOCK_CYCLES);
        end
    end

    pwd_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            unlock      <= 1'b0;
            locked_out  <= 1'b0;
            busy        <= 1'b0;
            bad_attempt <= 1'b0;
            fail_cnt    <= '0;
            code        <= DEFAULT_CODE;
            shadow      <= '0;
            idx         <= '0;
            pidx        <= '0;
            mismatch    <= 1'b0;
        end else begin
            bad_attempt <= 1'b0;
            case (state)
                IDLE, ENTRY: begin
                    if (fail_evt) begin
                        bad_attempt <= 1'b1;
                        fail_cnt    <= fail_next;
                        idx         <= '0;
                        mismatch    <= 1'b0;
                        busy        <= 1'b0;
                        if (to_lock) begin
                            state      <= LOCKOUT;
                            locked_out <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (pass_evt) begin
                        state    <= OPEN;
                        unlock   <= 1'b1;
                        fail_cnt <= '0;
                        idx      <= '0;
                        pidx     <= '0;
                        mismatch <= 1'b0;
                        busy     <= 1'b0;
                    end else if (accept) begin
                        state    <= ENTRY;
                        busy     <= 1'b1;
                        idx      <= idx + 1'b1;
                        mismatch <= attempt_mm;
                    end
                end
                OPEN: begin
                    if (tmr_expired) begin
                        state  <= IDLE;
                        unlock <= 1'b0;
                        pidx   <= '0;
                    end else if (prog_wr) begin
                        shadow <= shadow_next;
                        if (prog_done) begin
                            code   <= shadow_next;
                            state  <= IDLE;
                            unlock <= 1'b0;
                            pidx   <= '0;
                        end else begin
                            pidx <= pidx + 1'b1;
                        end
                    end
                end
                LOCKOUT: begin
                    if (tmr_expired) begin
                        state      <= IDLE;
                        locked_out <= 1'b0;
                        fail_cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwd_lockout_ctrl.sv
// Directed bench for pwd_lockout_ctrl with a queue of expected results.
module tb_pwd_lockout_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [1:0] key = 2'b00;
    logic       prog = 1'b0;
    logic       unlock, locked_out, busy, bad_attempt;
    logic [1:0] fail_cnt;

    localparam logic [7:0] GOOD = 8'b11_01_10_10;
    localparam logic [7:0] BAD  = 8'b11_10_01_10;
    localparam logic [7:0] ONES = 8'b01_01_01_01;

    typedef struct {
        string       tag;
        logic [15:0] v;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   bad_cnt = 0;

    pwd_lockout_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key         (key),
        .prog        (prog),
        .unlock      (unlock),
        .locked_out  (locked_out),
        .busy        (busy),
        .bad_attempt (bad_attempt),
        .fail_cnt    (fail_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bad_attempt === 1'b1) bad_cnt++;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] k, input logic p);
        key_valid = 1'b1;
        key       = k;
        prog      = p;
        tick();
        key_valid = 1'b0;
        prog      = 1'b0;
    endtask

    // Symbols go out in entry order (bits [1:0] first), one idle cycle apart.
    task automatic attempt(input logic [7:0] c);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            send(c[2*i +: 2], 1'b0);
        end
    endtask

    task automatic wait_unlock_drop(output int n);
        n = 0;
        while (unlock === 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic push(input string tag, input logic [15:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic pop_check(input logic [15:0] obs);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed %0d expected a queued value", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                miscompares++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.v);
            end
        end
    endtask

    initial begin
        int n;
        int busy_seen;

        // Reset state
        tick();
        tick();
        push("rst_unlock", 0); push("rst_locked", 0); push("rst_busy", 0);
        push("rst_bad", 0);    push("rst_fail", 0);
        pop_check(16'(unlock)); pop_check(16'(locked_out)); pop_check(16'(busy));
        pop_check(16'(bad_attempt)); pop_check(16'(fail_cnt));
        rst = 1'b0;
        tick();

        // Default code unlocks for exactly 20 cycles
        push("s1_busy_mid", 1);
        send(2'b10, 1'b0);
        pop_check(16'(busy));
        tick(); send(2'b10, 1'b0);
        tick(); send(2'b01, 1'b0);
        tick();
        push("s1_unlock", 1); push("s1_fail", 0); push("s1_busy_end", 0);
        send(2'b11, 1'b0);
        pop_check(16'(unlock)); pop_check(16'(fail_cnt)); pop_check(16'(busy));
        push("s1_unlock_len", 20);
        wait_unlock_drop(n);
        pop_check(16'(n));
        push("s1_no_bad", 0);
        pop_check(16'(bad_cnt));
        tick();

        // Three wrong attempts -> lockout
        for (int a = 1; a <= 3; a++) begin
            push("s2_bad", 1);
            push("s2_fail", 16'(a));
            push("s2_locked", (a == 3) ? 16'd1 : 16'd0);
            attempt(BAD);
            pop_check(16'(bad_attempt)); pop_check(16'(fail_cnt)); pop_check(16'(locked_out));
            push("s2_bad_pulse_end", 0);
            tick();
            pop_check(16'(bad_attempt));
        end
        // Locked_out already held one cycle past the entry edge.
        n = 1;
        busy_seen = 0;
        while (locked_out === 1'b1 && n < 200) begin
            key_valid = 1'b1;
            key = 2'b10;
            if (busy === 1'b1) busy_seen = 1;
            n++;
            tick();
        end
        key_valid = 1'b0;
        push("s2_lock_len", 50); push("s2_ignored", 0);
        push("s2_exit_busy", 0); push("s2_exit_fail", 0);
        pop_check(16'(n)); pop_check(16'(busy_seen));
        pop_check(16'(busy)); pop_check(16'(fail_cnt));
        push("s2_after_unlock", 1);
        attempt(GOOD);
        pop_check(16'(unlock));
        wait_unlock_drop(n);
        tick();

        // Entry timeout after 16 idle cycles
        send(2'b10, 1'b0);
        repeat (15) tick();
        push("s3_busy_pre", 1); push("s3_bad_pre", 0);
        pop_check(16'(busy)); pop_check(16'(bad_attempt));
        tick();
        push("s3_bad", 1); push("s3_fail", 1); push("s3_busy", 0);
        pop_check(16'(bad_attempt)); pop_check(16'(fail_cnt)); pop_check(16'(busy));
        tick();

        // Reprogram to 01 x4
        push("s4_unlock", 1); push("s4_fail_clr", 0);
        attempt(GOOD);
        pop_check(16'(unlock)); pop_check(16'(fail_cnt));
        for (int i = 0; i < 4; i++) send(2'b01, 1'b1);
        push("s4_commit_idle", 0);
        pop_check(16'(unlock));
        tick();
        push("s4_old_bad", 1); push("s4_old_fail", 1);
        attempt(GOOD);
        pop_check(16'(bad_attempt)); pop_check(16'(fail_cnt));
        tick();
        push("s4_new_unlock", 1);
        attempt(ONES);
        pop_check(16'(unlock));

        // Partial programming then expiry keeps the live code
        send(2'b11, 1'b1);
        send(2'b11, 1'b1);
        push("s5_reload_len", 20);
        wait_unlock_drop(n);
        pop_check(16'(n));
        tick();
        push("s5_old_unlock", 1);
        attempt(ONES);
        pop_check(16'(unlock));
        wait_unlock_drop(n);
        tick();

        // Reset mid-entry restores the default code
        send(2'b10, 1'b0);
        tick();
        send(2'b10, 1'b0);
        push("s6_busy_mid", 1);
        pop_check(16'(busy));
        rst = 1'b1; tick(); rst = 1'b0;
        push("s6_rst_busy", 0); push("s6_rst_unlock", 0);
        pop_check(16'(busy)); pop_check(16'(unlock));
        tick();
        push("s6_default_unlock", 1);
        attempt(GOOD);
        pop_check(16'(unlock));
        wait_unlock_drop(n);
        tick();

        // Reset during lockout
        for (int a = 0; a < 3; a++) begin
            attempt(BAD);
            tick();
        end
        push("s6_lock", 1);
        pop_check(16'(locked_out));
        repeat (10) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        push("s6_rst_locked", 0); push("s6_rst_fail", 0); push("s6_rst_bad", 0);
        pop_check(16'(locked_out)); pop_check(16'(fail_cnt)); pop_check(16'(bad_attempt));
        tick();
        push("s6_final_unlock", 1);
        attempt(GOOD);
        pop_check(16'(unlock));

        push("bad_total", 8);
        pop_check(16'(bad_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
